// File: rtl/axi3_rd_arbiter_if.sv
// AXI3 read-channel request/response structs and the bus-side interface
// carrying one read master port (request struct, ARID, response struct, RID).
package axi3_rd_pkg;

   typedef struct packed {
      logic [3:0]  arid;
      logic [31:0] araddr;
      logic [3:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic [3:0]  arcache;
      logic        arvalid;
      logic        rready;
   } axi3_rd_req_t;

   typedef struct packed {
      logic        arready;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
   } axi3_rd_resp_t;

endpackage

interface axi3_rd_if #(
   parameter int BUS_WIDTH = 4
);
   import axi3_rd_pkg::*;

   axi3_rd_req_t           rd_req;
   logic [BUS_WIDTH-1:0]   arid;
   axi3_rd_resp_t          rd_resp;
   logic [BUS_WIDTH-1:0]   rid;

   modport master (output rd_req, output arid, input rd_resp, input rid);
   modport slave  (input rd_req, input arid, output rd_resp, output rid);
endinterface

// File: rtl/axi3_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read master among N_REQ requesters;
// one burst outstanding, grant held from AR issue through the last R beat.
module axi3_rd_arbiter
   import axi3_rd_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int BUS_WIDTH = 4,
   localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  axi3_rd_req_t    req_rd_req  [N_REQ],
   output axi3_rd_resp_t   req_rd_resp [N_REQ],
   axi3_rd_if.master       m,
   output logic            busy,
   output logic [GW-1:0]   grant_idx,
   output logic            rid_err
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [GW-1:0]        r_grant;
   logic [GW-1:0]        r_rr_ptr;
   logic [GW-1:0]        w_cand [N_REQ];
   logic [GW-1:0]        w_pick;
   logic                 w_found;
   logic                 w_last_beat;
   logic                 w_rid_err;
   logic                 w_beat;
   axi3_rd_req_t         w_req;
   logic [BUS_WIDTH-1:0] w_arid;

   // Scan order starts at the round-robin pointer and wraps modulo N_REQ.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_cand[gi] = GW'((int'(r_rr_ptr) + gi) % N_REQ);
   end

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rd_req[w_cand[i]].arvalid) begin
            w_found = 1'b1;
            w_pick  = w_cand[i];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the async reset returns all control state at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_found)
            r_grant <= w_pick;
         if (w_last_beat)
            r_rr_ptr <= GW'((int'(r_grant) + 1) % N_REQ);
      end
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a variable unassigned, which would infer a latch.
   always_comb begin
      w_next      = r_state;
      w_req       = '0;
      w_arid      = '0;
      w_rid_err   = 1'b0;
      w_last_beat = 1'b0;
      w_beat      = 1'b0;
      for (int i = 0; i < N_REQ; i++)
         req_rd_resp[i] = '0;

      case (r_state)
         S_IDLE: begin
            if (w_found)
               w_next = S_ADDR;
         end
         S_ADDR: begin
            w_req        = req_rd_req[r_grant];
            w_req.rready = 1'b0;
            w_req.arid   = 4'(r_grant);
            w_arid       = BUS_WIDTH'(r_grant);
            req_rd_resp[r_grant].arready = m.rd_resp.arready;
            // A requester withdrawing arvalid abandons the grant without
            // advancing the pointer.
            if (!req_rd_req[r_grant].arvalid)
               w_next = S_IDLE;
            else if (m.rd_resp.arready)
               w_next = S_DATA;
         end
         S_DATA: begin
            w_req.rready = req_rd_req[r_grant].rready;
            req_rd_resp[r_grant].rdata  = m.rd_resp.rdata;
            req_rd_resp[r_grant].rresp  = m.rd_resp.rresp;
            req_rd_resp[r_grant].rlast  = m.rd_resp.rlast;
            req_rd_resp[r_grant].rvalid = m.rd_resp.rvalid;
            w_beat    = m.rd_resp.rvalid && req_rd_req[r_grant].rready;
            w_rid_err = w_beat && (m.rid != BUS_WIDTH'(r_grant));
            if (w_beat && m.rd_resp.rlast) begin
               w_last_beat = 1'b1;
               w_next      = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign m.rd_req  = w_req;
   assign m.arid    = w_arid;
   assign busy      = (r_state != S_IDLE);
   assign grant_idx = r_grant;
   assign rid_err   = w_rid_err;

endmodule

// File: doc/axi3_rd_arbiter.md
Name: axi3_rd_arbiter

Overview:
- Shares one AXI3 read master port (axi3_rd_if, master modport) between N_REQ cache/uncached read requesters.
- Typical clients: icache refill, dcache refill, uncached load unit.
- Issues one outstanding burst at a time, with round-robin grant and the grant locked for the whole AR+R transaction.
- Sits between the cache refill units and the SoC AXI crossbar.

Parameters:
N_REQ, 2, number of requester ports (2..4)
BUS_WIDTH, 4, AXI ID width; must satisfy 2**BUS_WIDTH >= N_REQ

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_rd_req  in  N_REQ x axi3_rd_req_t (51b each)  per-requester AR/R request struct; arid from requester ignored
req_rd_resp  out  N_REQ x axi3_rd_resp_t (37b each)  per-requester response struct
m_rd_req  out  axi3_rd_req_t  to bus
m_arid  out  BUS_WIDTH  ID of issued burst = granted requester index
m_rd_resp  in  axi3_rd_resp_t  from bus
m_rid  in  BUS_WIDTH  returned read ID
busy  out  1  high in any state other than IDLE
grant_idx  out  $clog2(N_REQ) (min 1)  currently granted requester, valid when busy
rid_err  out  1  one-cycle pulse on a beat whose m_rid != grant_idx

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant_idx=0, rr_ptr=0, busy=0, rid_err=0.
  - m_rd_req all-zero (arvalid=0, rready=0); m_arid=0.
  - All req_rd_resp zero (arready=0, rvalid=0).
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Selects the first requester with arvalid=1, scanning from rr_ptr upward modulo N_REQ.
  - If one is found: grant_idx is registered, state goes to ADDR next cycle. No arvalid is forwarded in IDLE, so there is 1 cycle of arbitration latency.
  - If none is found, stay in IDLE.
- ADDR:
  - m_rd_req AR fields = req_rd_req[grant_idx] AR fields (combinational pass-through); m_arid=grant_idx.
  - req_rd_resp[grant_idx].arready = m_rd_resp.arready.
  - On arvalid & arready: go to DATA.
  - If the granted requester drops arvalid before the handshake (protocol violation): return to IDLE, with no pointer update.
- DATA:
  - m_rd_req.rready = req_rd_req[grant_idx].rready; m_rd_req.arvalid=0.
  - req_rd_resp[grant_idx] rdata/rresp/rlast/rvalid = bus values.
  - On rvalid & rready & rlast: state goes to IDLE, and rr_ptr = (grant_idx+1) mod N_REQ.
- Non-granted requesters: arready=0, rvalid=0, rlast=0, at all times. rdata may be don't-care; drive 0.
- Beats with m_rid != grant_idx are still forwarded to the grant (single outstanding burst). rid_err pulses for 1 cycle as a debug flag.
- Simultaneous requests: the lowest index at or above rr_ptr wins. After a complete burst, that requester has lowest priority.
- A requester that keeps arvalid high through back-to-back bursts gets served again only after the others, if others are pending. With no others pending it is re-granted; the gap is 1 idle cycle.
- No combinational path from m_rd_resp to m_rd_req. arready and r* are passed through to the requester only.
- Reset mid-burst: immediately returns to IDLE with outputs at reset values. Orphaned bus beats are the system's responsibility.
- rvalid arriving in IDLE or ADDR (spurious): not forwarded, rready=0, rid_err=0.

Test Plan:
1. Single requester: req0 arvalid, araddr=0x1FC0_0000, arlen=3, arready after 2 cycles, 4 beats 0xA0..0xA3. Required:
   - m_arid=0.
   - req0 receives 4 beats in order with rlast on the 4th.
   - busy falls the cycle after the last beat; rr_ptr=1.
2. Simultaneous: req0 and req1 both arvalid from reset, arlen=0 each. Required:
   - req0 is granted first; req1 is granted next, with m_arid=1.
   - After both complete, rr_ptr=0.
3. Fairness: req0 holds arvalid continuously while req1 asserts mid-burst of req0. Required: next grant=1, not 0. Repeat for 3 rounds; grants alternate 0,1,0,1.
4. Backpressure: granted requester holds rready=0 for 3 cycles during beat 2. Required:
   - m rready=0 for those cycles.
   - No beat is lost or duplicated; data order is preserved.
5. ID mismatch: bus returns m_rid=2 while grant_idx=0. Required: data is forwarded to req0; rid_err=1 for exactly that beat's cycle.
6. Reset mid-DATA (after beat 1 of 4): assert rst asynchronously. Required:
   - Same cycle: busy=0, m arvalid=rready=0, req rvalid=0.
   - After rst deasserts, a new req1 request is granted normally.
